// File: rtl/bcd_to_bin_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM state encoding and
// the digit geometry / correction constants of the reverse double-dabble step.
// No ports; imported by every other file of the converter.
package bcd_to_bin_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    // A shifted digit at or above 8 held a borrowed "10" from its upper
    // neighbour; subtracting 3 turns that binary 16/2 = 8 into the decimal 5.
    localparam int ADJ_THRESH = 8;
    localparam int ADJ_VAL    = 3;

endpackage

// File: rtl/bcd_to_bin_if.sv
// Handshake/data bundle between a controller and the BCD-to-binary converter.
// master: drives start and the four BCD digits, observes ready/done_tick/bin.
// slave : the converter side, the mirror image of master.
interface bcd_to_bin_if #(
    parameter int W = 14
);
    logic         start;
    logic [3:0]   bcd3;
    logic [3:0]   bcd2;
    logic [3:0]   bcd1;
    logic [3:0]   bcd0;
    logic         ready;
    logic         done_tick;
    logic [W-1:0] bin;

    modport master (
        output start, bcd3, bcd2, bcd1, bcd0,
        input  ready, done_tick, bin
    );

    modport slave (
        input  start, bcd3, bcd2, bcd1, bcd0,
        output ready, done_tick, bin
    );
endinterface

// File: rtl/bcd_to_bin_digit_adj.sv
// Purpose: per-digit correction of one reverse double-dabble step (>=8 -> -3).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of din_i.
// Ports: din_i - digit after the right shift, dout_o - corrected digit.
module bcd_digit_adj
    import bcd_to_bin_pkg::*;
(
    input  logic [DIGIT_W-1:0] din_i,
    output logic [DIGIT_W-1:0] dout_o
);

    always_comb begin
        dout_o = din_i;
        if (din_i >= DIGIT_W'(ADJ_THRESH)) begin
            dout_o = din_i - DIGIT_W'(ADJ_VAL);
        end
    end

endmodule

// File: rtl/bcd_to_bin.sv
// Purpose: 4-digit packed BCD to unsigned binary, one result bit per clock.
// Latency: done_tick W cycles after the start edge; one conversion per W+2 cycles.
// Backpressure: start is only accepted while ready=1, otherwise ignored.
// Ports: clk, reset (synchronous, active-high); bus (slave modport) carries
//        start/bcd3..bcd0 in and ready/done_tick/bin out.
module bcd_to_bin
    import bcd_to_bin_pkg::*;
#(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    bcd_to_bin_if.slave  bus
);

    localparam int CNT_W = $clog2(W + 1);
    localparam int REG_W = NUM_DIGITS * DIGIT_W;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [REG_W-1:0]   dig_q,   dig_d;
    logic [W-1:0]       bin_q,   bin_d;

    logic [REG_W-1:0]   dig_shift;
    logic [REG_W-1:0]   dig_adj;

    // The whole digit string shifts as one register; each digit's LSB falls
    // into the MSB of the digit below, and d0's LSB leaves toward bin.
    assign dig_shift = dig_q >> 1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din_i  (dig_shift[g*DIGIT_W +: DIGIT_W]),
            .dout_o (dig_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dig_q   <= '0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            bin_q   <= bin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        bin_d   = bin_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dig_d   = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
                    bin_d   = '0;
                    cnt_d   = CNT_W'(W);
                    state_d = OP;
                end
            end
            OP: begin
                dig_d = dig_adj;
                bin_d = {dig_q[0], bin_q[W-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                // cnt_q==1 means this edge performs the last iteration.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready     = (state_q == IDLE);
    assign bus.done_tick = (state_q == DONE);
    assign bus.bin       = bin_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bcd_to_bin_if #(.W(14)) if14 ();
    bcd_to_bin_if #(.W(16)) if16 ();

    bcd_to_bin #(.W(14)) dut14 (
        .clk   (clk),
        .reset (reset),
        .bus   (if14.slave)
    );

    bcd_to_bin #(.W(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rd_ready(input bit sel);
        return sel ? if16.ready : if14.ready;
    endfunction

    function automatic logic rd_done(input bit sel);
        return sel ? if16.done_tick : if14.done_tick;
    endfunction

    function automatic logic [15:0] rd_bin(input bit sel);
        return sel ? if16.bin : {2'b00, if14.bin};
    endfunction

    task automatic drive(input bit sel, input logic st,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        if (sel) begin
            if16.start = st; if16.bcd3 = a; if16.bcd2 = b; if16.bcd1 = c; if16.bcd0 = d;
        end else begin
            if14.start = st; if14.bcd3 = a; if14.bcd2 = b; if14.bcd1 = c; if14.bcd0 = d;
        end
    endtask

    // One full conversion: load at edge 0, expect done_tick only after edge W,
    // ready low throughout OP/DONE, idle with held result after edge W+1.
    task automatic do_conv(input bit sel, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d,
                           input logic [15:0] exp_bin, input string nm);
        int w, ndone, done_at, rdy_bad;
        logic [15:0] bin_at_done;
        w = sel ? 16 : 14;
        @(negedge clk);
        checks++;
        if (rd_ready(sel) !== 1'b1) begin
            errors++; $display("FAIL %s ready_before got=%b want=1", nm, rd_ready(sel));
        end
        drive(sel, 1'b1, a, b, c, d);
        @(posedge clk);
        @(negedge clk);
        // Digits are scrambled after the load edge; the result must not change.
        drive(sel, 1'b0, 4'h7, 4'h7, 4'h7, 4'h7);
        ndone = 0; done_at = -1; rdy_bad = 0; bin_at_done = 16'hxxxx;
        for (int k = 1; k <= w; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_done(sel) === 1'b1) begin
                ndone++; done_at = k; bin_at_done = rd_bin(sel);
            end
            if (rd_ready(sel) !== 1'b0) rdy_bad++;
        end
        checks++;
        if (ndone != 1) begin
            errors++; $display("FAIL %s done_count got=%0d want=1", nm, ndone);
        end
        checks++;
        if (done_at != w) begin
            errors++; $display("FAIL %s done_cycle got=%0d want=%0d", nm, done_at, w);
        end
        checks++;
        if (bin_at_done !== exp_bin) begin
            errors++; $display("FAIL %s bin got=%0d want=%0d", nm, bin_at_done, exp_bin);
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++; $display("FAIL %s ready_busy got=%0d high cycles want=0", nm, rdy_bad);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_ready(sel) !== 1'b1 || rd_done(sel) !== 1'b0) begin
            errors++; $display("FAIL %s idle_after got=ready%b/done%b want=1/0", nm,
                               rd_ready(sel), rd_done(sel));
        end
        checks++;
        if (rd_bin(sel) !== exp_bin) begin
            errors++; $display("FAIL %s bin_held got=%0d want=%0d", nm, rd_bin(sel), exp_bin);
        end
    endtask

    // Reset held with start high: reset must win and leave both DUTs idle.
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
        drive(1'b1, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (rd_ready(s[0]) !== 1'b1) begin
                errors++; $display("FAIL reset_ready%0d got=%b want=1", s, rd_ready(s[0]));
            end
            checks++;
            if (rd_done(s[0]) !== 1'b0) begin
                errors++; $display("FAIL reset_done%0d got=%b want=0", s, rd_done(s[0]));
            end
            checks++;
            if (rd_bin(s[0]) !== 16'd0) begin
                errors++; $display("FAIL reset_bin%0d got=%0d want=0", s, rd_bin(s[0]));
            end
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    endtask

    // start held high: loads at edges 0 and 16, done_tick after edges 14 and 30.
    task automatic test_back_to_back();
        int ndone, bad_at, bad_bin;
        @(negedge clk);
        drive(1'b0, 1'b1, 4'h0, 4'h0, 4'h1, 4'h9);
        @(posedge clk);
        ndone = 0; bad_at = 0; bad_bin = 0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 16) if14.start = 1'b0;
            if (if14.done_tick === 1'b1) begin
                ndone++;
                if (k != 14 && k != 30) bad_at++;
                if (if14.bin !== 14'd19) bad_bin++;
            end
        end
        checks++;
        if (ndone != 2) begin
            errors++; $display("FAIL b2b_done_count got=%0d want=2", ndone);
        end
        checks++;
        if (bad_at != 0) begin
            errors++; $display("FAIL b2b_done_timing got=%0d misplaced want=0", bad_at);
        end
        checks++;
        if (bad_bin != 0) begin
            errors++; $display("FAIL b2b_bin got=%0d wrong want=0 (value %0d)", bad_bin, if14.bin);
        end
        checks++;
        if (if14.ready !== 1'b1) begin
            errors++; $display("FAIL b2b_idle got=%b want=1", if14.ready);
        end
    endtask

    task automatic test_values();
        do_conv(1'b0, 4'h9, 4'h9, 4'h9, 4'h9, 16'd9999, "v9999");
        do_conv(1'b0, 4'h1, 4'h2, 4'h3, 4'h4, 16'd1234, "v1234");
        do_conv(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 16'd0,    "v0000");
        do_conv(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 16'd1000, "v1000");
    endtask

    // Second start during OP with new digits must be ignored.
    task automatic test_start_ignored();
        int ndone, rdy_bad;
        logic [13:0] got;
        @(negedge clk);
        drive(1'b0, 1'b1, 4'h2, 4'h5, 4'h0, 4'h7);
        @(posedge clk);
        @(negedge clk);
        if14.start = 1'b0;
        ndone = 0; rdy_bad = 0; got = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 5) drive(1'b0, 1'b1, 4'h9, 4'h9, 4'h9, 4'h9);
            if (k == 6 || k == 14) if14.start = 1'b0;
            if (k == 13) if14.start = 1'b1;
            if (if14.done_tick === 1'b1) begin ndone++; got = if14.bin; end
            if (k <= 14 && if14.ready !== 1'b0) rdy_bad++;
        end
        checks++;
        if (got !== 14'd2507) begin
            errors++; $display("FAIL ign_bin got=%0d want=2507", got);
        end
        checks++;
        if (ndone != 1) begin
            errors++; $display("FAIL ign_done_count got=%0d want=1", ndone);
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++; $display("FAIL ign_ready got=%0d high cycles want=0", rdy_bad);
        end
    endtask

    // Reset 5 cycles into OP aborts; no done_tick; then a clean conversion.
    task automatic test_reset_mid();
        int ndone;
        @(negedge clk);
        drive(1'b0, 1'b1, 4'h3, 4'h3, 4'h3, 4'h3);
        @(posedge clk);
        @(negedge clk);
        if14.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (if14.ready !== 1'b1 || if14.bin !== 14'd0) begin
            errors++; $display("FAIL midrst_state got=ready%b/bin%0d want=1/0", if14.ready, if14.bin);
        end
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (if14.done_tick === 1'b1) ndone++;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (ndone != 0) begin
            errors++; $display("FAIL midrst_done got=%0d want=0", ndone);
        end
        do_conv(1'b0, 4'h0, 4'h4, 4'h5, 4'h6, 16'd456, "after_reset456");
    endtask

    task automatic test_w16();
        do_conv(1'b1, 4'h9, 4'h9, 4'h9, 4'h9, 16'd9999, "w16_9999");
        do_conv(1'b1, 4'h0, 4'h0, 4'h1, 4'h9, 16'd19,   "w16_0019");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        test_reset();
        test_back_to_back();
        test_values();
        test_start_ignored();
        test_reset_mid();
        test_w16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
